// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounced press/release
// detection. Columns are driven active-low one at a time; rows are sampled
// once per column dwell at the divider's last count (the "sample point").
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_onehot,
    output logic        key_valid,
    output logic        key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    // The sample that enters DEBOUNCE/RELEASE is already match 1, so the
    // counter only has to reach DEB_CNT-2 on the following matches.
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 2);

    typedef enum logic [1:0] {
        IDLE_SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t           state;
    logic [3:0]       row_meta;
    logic [3:0]       row_s;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [DEB_W-1:0] deb_cnt;
    logic [3:0]       cap_row;
    logic             load_pend;

    logic scan_hold;
    logic sample_pt;
    logic one_low;
    logic all_high;
    logic row_match;

    function automatic logic exactly_one_low(input logic [3:0] r);
        logic [3:0] z;
        z = ~r;
        return (z != 4'b0000) && ((z & (z - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd3;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        return idx;
    endfunction

    // Decode of the current cycle: scanning paused, sample point, row shape
    always_comb begin
        scan_hold = (state == IDLE_SCAN) && !scan_en;
        sample_pt = (div_cnt == DIV_LAST) && !scan_hold;
        one_low   = exactly_one_low(row_s);
        all_high  = (row_s == 4'hF);
        row_match = (row_s == cap_row);
    end

    // Two-flop synchronizer for the asynchronous row inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_s    <= 4'hF;
        end else begin
            row_meta <= row_in;
            row_s    <= row_meta;
        end
    end

    // Column dwell divider; frozen while scanning is paused in IDLE_SCAN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!scan_hold) begin
            if (div_cnt == DIV_LAST) div_cnt <= '0;
            else                     div_cnt <= div_cnt + 1'b1;
        end
    end

    // Scan/debounce FSM with registered column drive and key outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE_SCAN;
            col_idx    <= '0;
            deb_cnt    <= '0;
            cap_row    <= 4'hF;
            load_pend  <= 1'b0;
            col_out    <= 4'hF;
            key_onehot <= '0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            col_out   <= scan_hold ? 4'hF : ~(4'b0001 << col_idx);

            // Key outputs follow one edge after the FSM reaches PRESSED
            if (load_pend) begin
                load_pend  <= 1'b0;
                key_onehot <= 16'h0001 << {low_index(cap_row), col_idx};
                key_valid  <= 1'b1;
                key_held   <= 1'b1;
            end

            case (state)
                IDLE_SCAN: begin
                    if (sample_pt) begin
                        if (one_low) begin
                            cap_row <= row_s;
                            deb_cnt <= '0;
                            if (DEB_CNT == 1) begin
                                state     <= PRESSED;
                                load_pend <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sample_pt) begin
                        if (row_match) begin
                            if (deb_cnt == DEB_LAST) begin
                                state     <= PRESSED;
                                load_pend <= 1'b1;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            state   <= IDLE_SCAN;
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                end
                PRESSED: begin
                    if (sample_pt && all_high) begin
                        deb_cnt <= '0;
                        if (DEB_CNT == 1) begin
                            state    <= IDLE_SCAN;
                            key_held <= 1'b0;
                            col_idx  <= col_idx + 2'd1;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (sample_pt) begin
                        if (all_high) begin
                            if (deb_cnt == DEB_LAST) begin
                                state    <= IDLE_SCAN;
                                key_held <= 1'b0;
                                col_idx  <= col_idx + 2'd1;
                            end else begin
                                deb_cnt <= deb_cnt + 1'b1;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                end
                default: state <= IDLE_SCAN;
            endcase
        end
    end

endmodule
